// File: rtl/image_buffer_ctrl.sv
// image_buffer_ctrl: loads a raster image into a 1-cycle-latency BRAM, then streams it out with valid/ready/last.
// Optional IMG_CTRL_REPLAY_EN: readout returns to LOADED for re-streaming; a clear input forces a new load.
module image_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_PIXELS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  start,
`ifdef IMG_CTRL_REPLAY_EN
  input  logic                  clear,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  image_loaded,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {LOAD, LOADED, STREAM} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_PIXELS - 1);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic in_hs, out_hs;
  always_comb begin
    in_ready       = state == LOAD;
    out_valid      = state == STREAM;
    busy           = out_valid;
    image_loaded   = state != LOAD;
    out_last       = out_valid && rd_idx == LAST;
    out_data       = mem_read_data;
    in_hs          = in_valid && in_ready;
    out_hs         = out_valid && out_ready;
    mem_write_en   = in_hs;
    mem_write_addr = wr_idx;
    mem_write_data = in_data;
    // Prefetch the next pixel on a handshake, otherwise re-read the current one to hold out_data.
    mem_read_addr  = out_valid ? ((out_ready && !out_last) ? rd_idx + 1'b1 : rd_idx) : '0;
  end
  always_comb begin
    state_n = state;
    if (state == LOAD && in_hs && wr_idx == LAST) state_n = LOADED;
`ifdef IMG_CTRL_REPLAY_EN
    if (state == LOADED) state_n = clear ? LOAD : start ? STREAM : LOADED;
    if (out_hs && out_last) state_n = LOADED;
`else
    if (state == LOADED && start) state_n = STREAM;
    if (out_hs && out_last) state_n = LOAD;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= LOAD;
      wr_idx <= '0;
      rd_idx <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      done   <= out_hs && out_last;
      wr_idx <= in_hs ? (wr_idx == LAST ? '0 : wr_idx + 1'b1) : wr_idx;
      rd_idx <= state == LOADED ? '0 : out_hs ? (out_last ? '0 : rd_idx + 1'b1) : rd_idx;
    end
  end
endmodule

// File: tb/tb_image_buffer_ctrl.sv
// tb_image_buffer_ctrl: directed + randomized bench with a BRAM model and an image-array scoreboard.
module tb_image_buffer_ctrl;
  logic       clk = 0, rst = 1, in_valid = 0, start = 0, out_ready = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, out_valid, out_last, mem_write_en, image_loaded, busy, done;
  logic [7:0] out_data, mem_write_data, mem_read_data;
  logic [3:0] mem_write_addr, mem_read_addr;
`ifdef IMG_CTRL_REPLAY_EN
  logic       clear = 0;
`endif
  logic [7:0] mem [16];
  logic [7:0] img [16];
  int tests = 0, fails = 0;

  image_buffer_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .start(start),
`ifdef IMG_CTRL_REPLAY_EN
    .clear(clear),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
    .image_loaded(image_loaded), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
    mem_read_data <= mem[mem_read_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_image_loaded"}, 32'(image_loaded), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_out_last"}, 32'(out_last), 0);
  endtask

`ifdef IMG_CTRL_REPLAY_EN
  task automatic do_clear();
    @(negedge clk); clear = 1; start = 1; #1;
    check("clr_pending_loaded", 32'(image_loaded), 1);
    @(negedge clk); clear = 0; start = 0; #1;
    check("clr_in_ready", 32'(in_ready), 1);
    check("clr_image_loaded", 32'(image_loaded), 0);
  endtask
`endif

  // mode: 0 = contiguous with base+k, 1 = every other cycle with early start pulses, 2 = random gaps/data
  task automatic load(input int mode, input logic [7:0] base);
    int k = 0, cyc = 0;
`ifdef IMG_CTRL_REPLAY_EN
    if (image_loaded === 1'b1) do_clear();
`endif
    while (k < 16 && cyc < 200) begin
      @(negedge clk);
      in_valid  = mode == 1 ? (cyc % 2 == 0) : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data   = mode == 2 ? 8'($urandom) : 8'(base + k);
      start     = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      check("ld_in_ready", 32'(in_ready), 1);
      check("ld_image_loaded", 32'(image_loaded), 0);
      check("ld_out_valid", 32'(out_valid), 0);
      check("ld_we", 32'(mem_write_en), 32'(in_valid));
      if (in_valid) begin
        check("ld_addr", 32'(mem_write_addr), 32'(k));
        check("ld_wdata", 32'(mem_write_data), 32'(in_data));
        img[k] = in_data;
        k++;
      end
      cyc++;
    end
    if (k < 16) check("ld_timeout", 32'(k), 16);
    @(negedge clk); in_valid = 1; start = 0; #1;
    check("ld_done_in_ready", 32'(in_ready), 0);
    check("ld_done_image_loaded", 32'(image_loaded), 1);
    check("ld_done_we", 32'(mem_write_en), 0);
    check("ld_done_raddr", 32'(mem_read_addr), 0);
    in_valid = 0;
  endtask

  // mode: 0 = out_ready high, 1 = pattern 1,0,0,1,0,1, 2 = random; abort_at >= 0 resets while presenting that pixel
  task automatic stream(input int mode, input int abort_at);
    int j = 0, cyc = 0;
    logic [5:0] pat = 6'b101001;
    @(negedge clk); start = 1; in_valid = 1; #1;
    check("st_start_out_valid", 32'(out_valid), 0);
    check("st_start_loaded", 32'(image_loaded), 1);
    check("st_start_we", 32'(mem_write_en), 0);
    while (j < 16 && cyc < 300) begin
      @(negedge clk);
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 6] : 1'($urandom_range(0, 1));
      if (j == abort_at) rst = 1;
      #1;
      check("st_out_valid", 32'(out_valid), 1);
      check("st_busy", 32'(busy), 1);
      check("st_data", 32'(out_data), 32'(img[j]));
      check("st_last", 32'(out_last), 32'(j == 15));
      check("st_we", 32'(mem_write_en), 0);
      check("st_in_ready", 32'(in_ready), 0);
      check("st_done", 32'(done), 0);
      if (rst) begin
        @(negedge clk); rst = 0; start = 0; in_valid = 0; #1;
        check_idle("rst");
        check("rst_raddr", 32'(mem_read_addr), 0);
        return;
      end
      if (out_ready) j++;
      cyc++;
    end
    if (j < 16) check("st_timeout", 32'(j), 16);
    if (mode == 0) check("st_cycles", 32'(cyc), 16);
    @(negedge clk); start = 0; in_valid = 0; out_ready = 1; #1;
    check("end_done", 32'(done), 1);
    check("end_out_valid", 32'(out_valid), 0);
`ifdef IMG_CTRL_REPLAY_EN
    check("end_image_loaded", 32'(image_loaded), 1);
    check("end_in_ready", 32'(in_ready), 0);
`else
    check("end_image_loaded", 32'(image_loaded), 0);
    check("end_in_ready", 32'(in_ready), 1);
`endif
    @(negedge clk); #1;
    check("end_done_pulse", 32'(done), 0);
  endtask

  initial begin
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_we", 32'(mem_write_en), 0);
    rst = 0;
    load(0, 8'h10);
    repeat (3) begin
      @(negedge clk); in_valid = 1; start = 0; #1;
      check("hold_loaded", 32'(image_loaded), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_we", 32'(mem_write_en), 0);
    end
    stream(0, -1);
`ifdef IMG_CTRL_REPLAY_EN
    stream(0, -1);
    do_clear();
`endif
    load(1, 8'h40);
    stream(1, -1);
    load(0, 8'h20);
    stream(0, 7);
    load(0, 8'hA0);
    stream(0, -1);
    repeat (4) begin
      load(2, 8'h00);
      stream(2, -1);
`ifdef IMG_CTRL_REPLAY_EN
      stream(1, -1);
`endif
    end
    load(2, 8'h00);
    stream(2, $urandom_range(0, 15));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/image_buffer_ctrl.md
Name: image_buffer_ctrl

Overview:
- Sequences one 16-pixel image buffer: a synchronous-write, 1-cycle-latency registered-read BRAM with 8-bit data and a 4-bit address.
- Accepts a pixel stream from the input loader with a valid/ready handshake and writes it in raster order.
- On start, streams the stored image to the first neural-network layer with valid/ready/last, at one pixel per cycle and with no bubbles.
- Sits between the pixel source, the BRAM and the layer datapath.

Parameters:
- DATA_WIDTH, 8, pixel width; matches the BRAM data width.
- ADDR_WIDTH, 4, BRAM address width.
- NUM_PIXELS, 16, pixels per image; must satisfy 2 <= NUM_PIXELS <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input pixel valid.
- in_data  in  DATA_WIDTH  input pixel.
- in_ready  out  1  controller accepts a pixel.
- start  in  1  request readout; sampled only in LOADED.
- out_valid  out  1  output pixel valid.
- out_data  out  DATA_WIDTH  output pixel; driven directly from mem_read_data.
- out_last  out  1  marks the final pixel of the image.
- out_ready  in  1  downstream accepts a pixel.
- mem_write_en  out  1  BRAM write enable.
- mem_write_addr  out  ADDR_WIDTH  BRAM write address.
- mem_write_data  out  DATA_WIDTH  BRAM write data.
- mem_read_addr  out  ADDR_WIDTH  BRAM read address.
- mem_read_data  in  DATA_WIDTH  BRAM registered read data.
- image_loaded  out  1  a complete image is stored.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- States: LOAD, LOADED, STREAM. Reset state is LOAD.
- Reset values: in_ready=1 (state is LOAD), out_valid=0, out_last=0, image_loaded=0, busy=0, done=0, wr_idx=0, rd_idx=0. BRAM contents are not cleared.
- LOAD:
  - in_ready=1.
  - mem_write_en = in_valid; mem_write_addr = wr_idx; mem_write_data = in_data (all combinational).
  - Each in_valid&&in_ready increments wr_idx.
  - The handshake at wr_idx==NUM_PIXELS-1 moves to LOADED and resets wr_idx to 0.
  - Gaps in in_valid stall loading without losing position.
- LOADED:
  - in_ready=0, image_loaded=1.
  - start moves to STREAM next cycle with rd_idx=0.
- STREAM:
  - out_valid=1, busy=1; out_last=(rd_idx==NUM_PIXELS-1).
  - On out_valid&&out_ready: rd_idx increments.
  - The handshake with out_last returns to LOAD: image_loaded clears and done pulses the following cycle.
- Read addressing (combinational):
  - In STREAM: mem_read_addr = rd_idx+1 when out_ready && !out_last, else rd_idx.
  - In all other states: mem_read_addr = 0.
  - This pre-fetches the next pixel on a handshake and holds the current pixel under backpressure, so out_data stays stable while out_valid && !out_ready.
  - out_ready therefore has a combinational path to mem_read_addr.
- Latency:
  - start sampled at cycle N gives out_valid=1 at N+1 with pixel 0.
  - The full image takes NUM_PIXELS cycles when out_ready is held high.
- Load-to-start ordering: start is ignored in LOAD and STREAM. LOADED always lasts at least one cycle, so the BRAM never returns stale data for pixel 0.
- Write/read exclusion: mem_write_en=0 outside LOAD; no write ever occurs in STREAM.
- Counters are ADDR_WIDTH bits wide and never wrap past NUM_PIXELS-1.
- rst mid-load or mid-stream: returns to LOAD next cycle with all outputs at reset values. A partial image is discarded and must be reloaded in full.

Optional Feature:
- Macro IMG_CTRL_REPLAY_EN.
- Defined: the final handshake in STREAM returns to LOADED instead of LOAD, and image_loaded stays 1. The same image can be re-streamed with start any number of times. A new load requires the clear input (1 bit, in, present only with the macro); clear sampled in LOADED moves to LOAD.
- Undefined: there is no clear port, and every readout returns to LOAD as described above.

Test Plan:
- Load: reset, then drive in_data 0x10..0x1F with in_valid held high. Expect mem_write_addr 0..15 and in_ready=0 from the cycle after the 16th beat. image_loaded=1 from that cycle.
- Stream: assert start for one cycle with out_ready=1. Expect out_data 0x10..0x1F on 16 consecutive cycles starting one cycle after start. out_last only with 0x1F; done pulses the cycle after; in_ready=1 afterwards.
- Backpressure: stream with out_ready pattern 1,0,0,1,0,1... Expect out_data to hold through each stall, no pixel dropped or duplicated, and 16 handshakes total.
- Gapped load and early start: in_valid high every other cycle, with start pulsed during LOAD. Expect start ignored, all 16 pixels written to correct addresses, then LOADED.
- Reset mid-stream: rst at the 8th pixel. Expect out_valid=0, image_loaded=0, in_ready=1 the next cycle. A reload of 0xA0..0xAF then streams 0xA0..0xAF.
- With IMG_CTRL_REPLAY_EN: stream twice with no reload, expecting the identical 0x10..0x1F sequence both times. Then pulse clear, expecting in_ready=1.
